// File: rtl/comparator_accumulator.sv
// Streaming arg-max/arg-min over up to DEPTH handshake beats.
// Emits the winning element and its 0-based beat index once per group.
module comparator_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter bit MAX1_MIN0  = 1'b1,
  parameter bit SIGNED     = 1'b0,
  localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

  // Strict compare: a tie keeps the earlier beat.
  function automatic logic f_better(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    logic gt;
    logic lt;
    if (SIGNED) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return MAX1_MIN0 ? gt : lt;
  endfunction

  logic [IDX_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_acc_val;
  logic [IDX_WIDTH-1:0]  r_acc_idx;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [IDX_WIDTH-1:0]  r_out_idx;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_close;
  logic                  w_out_hs;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_win_val;
  logic [IDX_WIDTH-1:0]  w_win_idx;

  assign in_ready  = rst && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_close   = w_accept && ((r_count == LAST_IDX) || in_last);
  assign w_out_hs  = r_out_valid && out_ready;

  // The first beat of a group always seeds the accumulator.
  always_comb begin
    w_take    = (r_count == '0) || f_better(in_data, r_acc_val);
    w_win_val = w_take ? in_data : r_acc_val;
    w_win_idx = w_take ? r_count : r_acc_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_acc_val   <= '0;
      r_acc_idx   <= '0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc_val <= w_win_val;
        r_acc_idx <= w_win_idx;
        r_count   <= w_close ? '0 : r_count + 1'b1;
      end
      // A close overrides a same-edge release so back-to-back groups stream.
      if (w_close) begin
        r_out_data  <= w_win_val;
        r_out_idx   <= w_win_idx;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_index = r_out_idx;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_comparator_accumulator.sv
// Scoreboard bench: unsigned-MAX and signed-MIN instances share one input stream.
module tb_comparator_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       out_ready;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_out_index;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_out_index;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: out_ready=1, 1: random out_ready, 2: driven by main thread

  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always #5 clk = ~clk;

  comparator_accumulator #(.DATA_WIDTH(8), .DEPTH(4), .MAX1_MIN0(1'b1), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_index(a_out_index),
    .out_valid(a_out_valid), .out_ready(out_ready)
  );

  comparator_accumulator #(.DATA_WIDTH(8), .DEPTH(4), .MAX1_MIN0(1'b0), .SIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_index(b_out_index),
    .out_valid(b_out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit bet(input logic [7:0] a, input logic [7:0] b, input bit mx, input bit sg);
    bit gt, lt;
    gt = sg ? ($signed(a) > $signed(b)) : (a > b);
    lt = sg ? ($signed(a) < $signed(b)) : (a < b);
    return mx ? gt : lt;
  endfunction

  function automatic logic [9:0] ref_red(input logic [7:0] b[4], input int n, input bit mx, input bit sg);
    logic [7:0] best;
    logic [1:0] bi;
    best = b[0];
    bi   = 2'd0;
    for (int i = 1; i < n; i++) begin
      if (bet(b[i], best, mx, sg)) begin
        best = b[i];
        bi   = 2'(i);
      end
    end
    return {bi, best};
  endfunction

  // out_ready only moves just after a rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: one output handshake per negedge sample at most
  always @(negedge clk) begin
    if (rst && a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_extra: got result 0x%0h idx %0d, expected no result", a_out_data, a_out_index);
      end else begin
        chk("a_result", 32'({a_out_index, a_out_data}), 32'(qa.pop_front()));
      end
    end
    if (rst && b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra: got result 0x%0h idx %0d, expected no result", b_out_data, b_out_index);
      end else begin
        chk("b_result", 32'({b_out_index, b_out_data}), 32'(qb.pop_front()));
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready got 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic issue_group(input logic [7:0] b[4], input int n, input bit close_last,
                             input logic [9:0] ea, input logic [9:0] eb, input bit gaps);
    qa.push_back(ea);
    qb.push_back(eb);
    for (int i = 0; i < n; i++) begin
      send_beat(b[i], close_last && (i == n - 1));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] b[4];
    int         n;
    bit         cl;
    int         w;

    rst = 1'b0; in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_out_index", 32'(a_out_index), 32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    b = '{8'd3, 8'd9, 8'd2, 8'd7};
    issue_group(b, 4, 1'b0, {2'd1, 8'd9}, {2'd2, 8'd2}, 1'b0);
    idle(4);
    chk("one_result_a", 32'(qa.size()), 32'd0);
    chk("one_result_b", 32'(qb.size()), 32'd0);

    b = '{8'h05, 8'hF0, 8'h80, 8'h7F};
    issue_group(b, 4, 1'b0, {2'd1, 8'hF0}, {2'd2, 8'h80}, 1'b0);
    b = '{8'd6, 8'd6, 8'd6, 8'd6};
    issue_group(b, 4, 1'b0, {2'd0, 8'd6}, {2'd0, 8'd6}, 1'b0);
    b = '{8'd4, 8'd8, 8'd0, 8'd0};
    issue_group(b, 2, 1'b1, {2'd1, 8'd8}, {2'd0, 8'd4}, 1'b0);
    b = '{8'd3, 8'd1, 8'd1, 8'd2};
    issue_group(b, 4, 1'b0, {2'd0, 8'd3}, {2'd1, 8'd1}, 1'b1);
    b = '{8'h42, 8'd0, 8'd0, 8'd0};
    issue_group(b, 1, 1'b1, {2'd0, 8'h42}, {2'd0, 8'h42}, 1'b0);
    idle(4);

    // Backpressure: result held, then released together with a closing beat
    mode = 2;
    out_ready = 1'b0;
    b = '{8'd1, 8'd5, 8'd2, 8'd3};
    issue_group(b, 4, 1'b0, {2'd1, 8'd5}, {2'd0, 8'd1}, 1'b0);
    @(negedge clk);
    chk("bp_in_ready",  32'(a_in_ready),  32'd0);
    chk("bp_out_valid", 32'(a_out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_data",  32'(a_out_data),  32'd5);
      chk("bp_hold_index", 32'(a_out_index), 32'd1);
    end
    @(posedge clk);
    #1;
    qa.push_back({2'd0, 8'd7});
    qb.push_back({2'd0, 8'd7});
    in_data = 8'd7; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("bp_overlap_valid", 32'(a_out_valid), 32'd1);
    chk("bp_overlap_data",  32'(a_out_data),  32'd7);
    mode = 0;
    idle(3);

    // Async reset mid-group
    send_beat(8'd10, 1'b0);
    send_beat(8'd20, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_out_valid), 32'd0);
    chk("arst_out_data",  32'(a_out_data),  32'd0);
    chk("arst_out_index", 32'(a_out_index), 32'd0);
    chk("arst_in_ready",  32'(a_in_ready),  32'd0);
    chk("arst_b_out_data", 32'(b_out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1);
    b = '{8'd1, 8'd2, 8'd3, 8'd4};
    issue_group(b, 4, 1'b0, {2'd3, 8'd4}, {2'd0, 8'd1}, 1'b0);
    idle(4);

    // Random gaps and group lengths against the reference model
    mode = 1;
    for (int g = 0; g < 1000; g++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      cl = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      issue_group(b, n, cl, ref_red(b, n, 1'b1, 1'b0), ref_red(b, n, 1'b0, 1'b1), 1'b1);
    end

    mode = 0;
    w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    idle(3);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    chk("end_out_valid", 32'(a_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
